axi_mem_responder: RTL

//  AXI4 subordinate that terminates ariane_axi::req_t/resp_t traffic on a single-port

---
 rtl/axi_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate terminating ariane_axi req/resp traffic on a single-port SRAM with
// 1-cycle read latency. One transaction in flight; reads and writes are serialized.
package ariane_axi;
   localparam int unsigned IdWidth   = 10;
   localparam int unsigned AddrWidth = 64;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned UserWidth = 1;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [5:0]           atop;
      logic [UserWidth-1:0] user;
   } aw_chan_t;

   typedef struct packed {
      logic [DataWidth-1:0]   data;
      logic [DataWidth/8-1:0] strb;
      logic                   last;
      logic [UserWidth-1:0]   user;
   } w_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [1:0]           resp;
      logic [UserWidth-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [UserWidth-1:0] user;
   } ar_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
      logic [UserWidth-1:0] user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;
endpackage

module axi_mem_responder
   import ariane_axi::*;
#(
   parameter int unsigned  DATA_WIDTH   = 64,
   parameter int unsigned  AXI_ID_WIDTH = 10,
   parameter logic [63:0]  MEM_BASE     = 64'h8000_0000,
   parameter int unsigned  MEM_BYTES    = 65536,
   localparam int unsigned STRB_W       = DATA_WIDTH / 8,
   localparam int unsigned IDX_W        = $clog2(MEM_BYTES / STRB_W)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  req_t                  axi_req_i,
   output resp_t                 axi_resp_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [IDX_W-1:0]      mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [STRB_W-1:0]     mem_be_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
   localparam int unsigned OFF_W       = $clog2(STRB_W);
   localparam logic [63:0] MEM_END     = MEM_BASE + 64'(MEM_BYTES);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WRITE      = 3'd1,
      WRITE_RESP = 3'd2,
      READ_REQ   = 3'd3,
      READ_CAPT  = 3'd4,
      READ_RESP  = 3'd5
   } state_e;

   state_e                  state_q, state_d;
   logic                    prio_q, prio_d;
   logic [AXI_ID_WIDTH-1:0] id_q, id_d;
   logic [63:0]             addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    decerr_q, decerr_d;
   logic                    slverr_q, slverr_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              r_resp_q, r_resp_d;
   logic                    r_last_q, r_last_d;
   logic [1:0]              b_resp_q, b_resp_d;

   logic        sel_w_s, sel_r_s, wr_beat_s, last_beat_s, last_bad_s;
   logic [63:0] offs_s, next_addr_s;
   logic        unused_s;

   function automatic logic in_range(input logic [63:0] a);
      return (a >= MEM_BASE) && (a < MEM_END);
   endfunction

   // WRAP stays inside the (len+1)<<size aligned block; illegal WRAP lengths fall back to INCR.
   function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [63:0] inc;
      logic [63:0] mask;
      logic        wrap_ok;
      inc     = a + (64'd1 << size);
      mask    = (({56'd0, len} + 64'd1) << size) - 64'd1;
      wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      case (burst)
         BURST_FIXED: next_addr = a;
         BURST_WRAP:  next_addr = wrap_ok ? ((a & ~mask) | (inc & mask)) : inc;
         default:     next_addr = inc;
      endcase
   endfunction

   assign sel_w_s     = axi_req_i.aw_valid & (~axi_req_i.ar_valid | ~prio_q);
   assign sel_r_s     = axi_req_i.ar_valid & (~axi_req_i.aw_valid | prio_q);
   assign wr_beat_s   = (state_q == WRITE) & axi_req_i.w_valid;
   assign last_beat_s = (cnt_q == len_q);
   assign last_bad_s  = axi_req_i.w.last != last_beat_s;
   assign offs_s      = addr_q - MEM_BASE;
   assign next_addr_s = next_addr(addr_q, len_q, size_q, burst_q);

   assign mem_req_o   = (wr_beat_s | (state_q == READ_REQ)) & ~decerr_q;
   assign mem_we_o    = wr_beat_s & ~decerr_q;
   assign mem_addr_o  = offs_s[OFF_W +: IDX_W];
   assign mem_wdata_o = wr_beat_s ? axi_req_i.w.data : '0;
   assign mem_be_o    = wr_beat_s ? axi_req_i.w.strb : '0;

   assign unused_s = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                       axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.atop,
                       axi_req_i.aw.user, axi_req_i.ar.lock, axi_req_i.ar.cache,
                       axi_req_i.ar.prot, axi_req_i.ar.qos, axi_req_i.ar.region,
                       axi_req_i.ar.user, axi_req_i.w.user, offs_s};

   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.aw_ready = (state_q == IDLE) & sel_w_s;
      axi_resp_o.ar_ready = (state_q == IDLE) & sel_r_s;
      axi_resp_o.w_ready  = (state_q == WRITE);
      axi_resp_o.b_valid  = (state_q == WRITE_RESP);
      axi_resp_o.b.id     = id_q;
      axi_resp_o.b.resp   = b_resp_q;
      axi_resp_o.r_valid  = (state_q == READ_RESP);
      axi_resp_o.r.id     = id_q;
      axi_resp_o.r.data   = rdata_q;
      axi_resp_o.r.resp   = r_resp_q;
      axi_resp_o.r.last   = r_last_q;
   end

   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      id_d     = id_q;
      addr_d   = addr_q;
      len_d    = len_q;
      size_d   = size_q;
      burst_d  = burst_q;
      cnt_d    = cnt_q;
      decerr_d = decerr_q;
      slverr_d = slverr_q;
      rdata_d  = rdata_q;
      r_resp_d = r_resp_q;
      r_last_d = r_last_q;
      b_resp_d = b_resp_q;
      case (state_q)
         IDLE: begin
            if (sel_w_s) begin
               state_d  = WRITE;
               prio_d   = ~prio_q;
               id_d     = axi_req_i.aw.id;
               addr_d   = axi_req_i.aw.addr;
               len_d    = axi_req_i.aw.len;
               size_d   = axi_req_i.aw.size;
               burst_d  = axi_req_i.aw.burst;
               cnt_d    = 8'd0;
               decerr_d = ~in_range(axi_req_i.aw.addr);
               slverr_d = 1'b0;
            end else if (sel_r_s) begin
               state_d  = READ_REQ;
               prio_d   = ~prio_q;
               id_d     = axi_req_i.ar.id;
               addr_d   = axi_req_i.ar.addr;
               len_d    = axi_req_i.ar.len;
               size_d   = axi_req_i.ar.size;
               burst_d  = axi_req_i.ar.burst;
               cnt_d    = 8'd0;
               decerr_d = ~in_range(axi_req_i.ar.addr);
               slverr_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (axi_req_i.w_valid) begin
               addr_d   = next_addr_s;
               cnt_d    = cnt_q + 8'd1;
               slverr_d = slverr_q | last_bad_s;
               // The beat count, not w.last, ends the burst; a w.last mismatch only flags SLVERR.
               if (last_beat_s) begin
                  state_d  = WRITE_RESP;
                  b_resp_d = decerr_q ? RESP_DECERR
                           : ((slverr_q | last_bad_s) ? RESP_SLVERR : RESP_OKAY);
               end else begin
                  state_d = WRITE;
               end
            end else begin
               state_d = WRITE;
            end
         end
         WRITE_RESP: begin
            state_d = axi_req_i.b_ready ? IDLE : WRITE_RESP;
         end
         READ_REQ: begin
            state_d = READ_CAPT;
         end
         READ_CAPT: begin
            rdata_d  = decerr_q ? '0 : mem_rdata_i;
            r_resp_d = decerr_q ? RESP_DECERR : RESP_OKAY;
            r_last_d = last_beat_s;
            state_d  = READ_RESP;
         end
         READ_RESP: begin
            if (axi_req_i.r_ready) begin
               if (r_last_q) begin
                  state_d = IDLE;
               end else begin
                  addr_d  = next_addr_s;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = READ_REQ;
               end
            end else begin
               state_d = READ_RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         id_q     <= '0;
         addr_q   <= 64'd0;
         len_q    <= 8'd0;
         size_q   <= 3'd0;
         burst_q  <= 2'd0;
         cnt_q    <= 8'd0;
         decerr_q <= 1'b0;
         slverr_q <= 1'b0;
         rdata_q  <= '0;
         r_resp_q <= 2'd0;
         r_last_q <= 1'b0;
         b_resp_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         cnt_q    <= cnt_d;
         decerr_q <= decerr_d;
         slverr_q <= slverr_d;
         rdata_q  <= rdata_d;
         r_resp_q <= r_resp_d;
         r_last_q <= r_last_d;
         b_resp_q <= b_resp_d;
      end
   end
endmodule
